// File: rtl/shift_add_multiplier_if.sv
// Multiply request/response bundle for the shift-and-add multiplier.
// master: i_start, i_multiplicand, i_multiplier out; o_busy, o_done, o_product in.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 2
);
    logic               i_start;
    logic [WIDTH-1:0]   i_multiplicand;
    logic [WIDTH-1:0]   i_multiplier;
    logic               o_busy;
    logic               o_done;
    logic [2*WIDTH-1:0] o_product;

    modport master (
        output i_start,
        output i_multiplicand,
        output i_multiplier,
        input  o_busy,
        input  o_done,
        input  o_product
    );

    modport slave (
        input  i_start,
        input  i_multiplicand,
        input  i_multiplier,
        output o_busy,
        output o_done,
        output o_product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one add per cycle through a ripple_carry_adder.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport):
//   i_start/i_multiplicand/i_multiplier in; o_busy/o_done/o_product out.

module ripple_carry_adder #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    output logic [WIDTH:0]   o_result
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_result[i]  = i_add_term1[i] ^ i_add_term2[i] ^ carry[i];
        assign carry[i+1]   = (i_add_term1[i] & i_add_term2[i])
                            | (carry[i] & (i_add_term1[i] ^ i_add_term2[i]));
    end

    assign o_result[WIDTH] = carry[WIDTH];
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   term2;
    logic [WIDTH:0]     sum;

    assign term2 = q_q[0] ? m_q : '0;

    ripple_carry_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .i_add_term1(a_q),
        .i_add_term2(term2),
        .o_result   (sum)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    m_d     = bus.i_multiplicand;
                    q_d     = bus.i_multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Adder carry lands in A's MSB; S[0] shifts into Q.
                a_d   = sum[WIDTH:1];
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    prod_d  = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_product = prod_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at WIDTH=2 and WIDTH=8.
// Drives both instances in parallel; a monitor checks every cycle.
module tb_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(2)) if2 ();
    shift_add_multiplier_if #(.WIDTH(8)) if8 ();

    shift_add_multiplier #(.WIDTH(2)) dut2 (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (if2)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (if8)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard FIFOs: expected product and the edge it completes at.
    int ep[2][1024];
    int ee[2][1024];
    int head[2];
    int tail[2];
    int nfree[2];
    int hold[2];

    function automatic int wd(input int k);
        return (k == 0) ? 2 : 8;
    endfunction

    task automatic model(input int k, input logic r, input logic s,
                         input int m, input int q, input int e);
        if (r) begin
            head[k]  = tail[k];
            nfree[k] = e + 1;
            hold[k]  = 0;
        end else if (s && e >= nfree[k]) begin
            ep[k][tail[k]] = m * q;
            ee[k][tail[k]] = e + wd(k);
            tail[k]        = tail[k] + 1;
            nfree[k]       = e + wd(k) + 2;
        end
    endtask

    task automatic drive(input logic r,
                         input logic s0, input logic [7:0] m0,
                         input logic [7:0] q0,
                         input logic s1, input logic [7:0] m1,
                         input logic [7:0] q1);
        int e;
        @(negedge clk);
        e = cyc + 1;
        rst                = r;
        if2.i_start        = s0;
        if2.i_multiplicand = m0[1:0];
        if2.i_multiplier   = q0[1:0];
        if8.i_start        = s1;
        if8.i_multiplicand = m1;
        if8.i_multiplier   = q1;
        model(0, r, s0, int'(m0[1:0]), int'(q0[1:0]), e);
        model(1, r, s1, int'(m1), int'(q1), e);
    endtask

    task automatic check(input int k, input logic done,
                         input logic busy, input logic [15:0] prod);
        logic exp_busy;
        exp_busy = (cyc < nfree[k] - 1);
        n_cmp++;
        if (busy !== exp_busy) begin
            n_err++;
            $display("FAIL busy w%0d cyc %0d: got %b want %b",
                     wd(k), cyc, busy, exp_busy);
        end
        if (head[k] != tail[k] && ee[k][head[k]] == cyc) begin
            n_cmp++;
            if (done !== 1'b1 || prod !== 16'(ep[k][head[k]])) begin
                n_err++;
                $display("FAIL product w%0d cyc %0d: done %b prod %0d want 1 %0d",
                         wd(k), cyc, done, prod, ep[k][head[k]]);
            end
            hold[k] = ep[k][head[k]];
            head[k] = head[k] + 1;
        end else begin
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL spurious_done w%0d cyc %0d: got %b want 0",
                         wd(k), cyc, done);
            end
        end
        n_cmp++;
        if (prod !== 16'(hold[k])) begin
            n_err++;
            $display("FAIL hold w%0d cyc %0d: got %0d want %0d",
                     wd(k), cyc, prod, hold[k]);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        check(0, if2.o_done, if2.o_busy, {12'd0, if2.o_product});
        check(1, if8.o_done, if8.o_busy, if8.o_product);
    end

    task automatic op(input logic [7:0] m0, input logic [7:0] q0,
                      input logic [7:0] m1, input logic [7:0] q1);
        drive(1'b0, 1'b1, m0, q0, 1'b1, m1, q1);
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b0, 8'($urandom), 8'($urandom),
                  1'b0, 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            head[k]  = 0;
            tail[k]  = 0;
            nfree[k] = 0;
            hold[k]  = 0;
        end
        if2.i_start = 1'b0;
        if2.i_multiplicand = '0;
        if2.i_multiplier = '0;
        if8.i_start = 1'b0;
        if8.i_multiplicand = '0;
        if8.i_multiplier = '0;
        // Initial reset covers edge 1; then two explicit reset cycles.
        drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);

        op(8'd3, 8'd3, 8'd255, 8'd255);
        op(8'd2, 8'd1, 8'd128, 8'd2);
        op(8'd1, 8'd3, 8'd0, 8'd255);
        op(8'd0, 8'd3, 8'd255, 8'd0);
        op(8'd3, 8'd0, 8'd1, 8'd1);

        // Start held high, operands changing every cycle.
        for (int i = 0; i < 44; i++) begin
            drive(1'b0, 1'b1, 8'($urandom), 8'($urandom),
                  1'b1, 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        end

        // Abort by reset one cycle after start, then a fresh multiply.
        drive(1'b0, 1'b1, 8'd3, 8'd3, 1'b1, 8'd200, 8'd100);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 8'd1, 8'd1);
        op(8'd2, 8'd3, 8'd17, 8'd15);

        // Random traffic, including starts while busy.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, ($urandom_range(2) == 0), 8'($urandom), 8'($urandom),
                  ($urandom_range(2) == 0), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        end

        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (head[k] != tail[k]) begin
                n_err++;
                $display("FAIL drain w%0d: %0d outstanding want 0",
                         wd(k), tail[k] - head[k]);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
